// File: rtl/count_display_drv.sv
// count_display_drv: mod-15 count -> two multiplexed 7-segment digits, plus WRAP/ERR flags.
// Optional: define BLANK_LEADING_ZERO_EN to darken the tens digit for values 0..9.
`default_nettype none

module count_display_drv #(
  parameter int REFRESH_DIV = 1000,
  parameter int PRESC_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Q,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       WRAP,
  output logic       ERR
);

  localparam logic [0:0] DIG_ONES = 1'b0;
  localparam logic [0:0] DIG_TENS = 1'b1;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  logic [3:0]         q_reg_q,  q_reg_d;
  logic [3:0]         q_prev_q, q_prev_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [0:0]         state_q,  state_d;
  logic [6:0]         seg_q,    seg_d;
  logic [1:0]         an_q,     an_d;
  logic               wrap_q,   wrap_d;
  logic               err_q,    err_d;

  logic               presc_term;
  logic               tens;
  logic [3:0]         ones;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

  assign presc_term = (presc_q == PRESC_W'(REFRESH_DIV - 1));
  assign tens       = (q_reg_q >= 4'd10);
  assign ones       = tens ? (q_reg_q - 4'd10) : q_reg_q;

  always_comb begin
    q_reg_d  = Q;
    q_prev_d = q_reg_q;
    presc_d  = presc_term ? '0 : presc_q + 1'b1;
    state_d  = presc_term ? ~state_q : state_q;
    // Display registers follow the phase and count held before this edge.
    an_d     = (state_q == DIG_ONES) ? 2'b01 : 2'b10;
    seg_d    = SEG_OFF;
    if (q_reg_q == 4'd15) begin
      seg_d = SEG_DASH;
    end else if (state_q == DIG_ONES) begin
      seg_d = seg_code(ones);
    end else begin
`ifdef BLANK_LEADING_ZERO_EN
      seg_d = tens ? seg_code(4'd1) : SEG_OFF;
`else
      seg_d = seg_code({3'b000, tens});
`endif
    end
    err_d  = (q_reg_q == 4'd15);
    wrap_d = (q_prev_q == 4'd14) && (q_reg_q == 4'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      q_reg_q  <= 4'd0;
      q_prev_q <= 4'd0;
      presc_q  <= '0;
      state_q  <= DIG_ONES;
      seg_q    <= SEG_OFF;
      an_q     <= 2'b00;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      q_reg_q  <= q_reg_d;
      q_prev_q <= q_prev_d;
      presc_q  <= presc_d;
      state_q  <= state_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign WRAP = wrap_q;
  assign ERR  = err_q;

endmodule

`default_nettype wire
